// File: rtl/fat_pkg.sv
// fat_pkg: shared FSM states, addressor selector codes and chain constants
package fat_pkg;
  typedef enum logic [2:0] {IDLE, DATA_REQ, DATA_WAIT, FAT_REQ, FAT_WAIT, FAT_REQ2, FAT_WAIT2} state_t;
  localparam logic [1:0] SEL_DIR = 2'b00;
  localparam logic [1:0] SEL_FAT = 2'b01;
  localparam logic [1:0] SEL_DATA = 2'b10;
  localparam logic [23:0] EOC_MIN_DEF = 24'hFFFFF8;
endpackage

// File: rtl/fat_addr_calc.sv
// fat_addr_calc: data sector, FAT sector and FAT entry byte position for one cluster
module fat_addr_calc
  import fat_pkg::*;
#(
  parameter int unsigned FAT_START_SECTOR = 32,
  parameter int unsigned DATA_START_SECTOR = 2048,
  parameter int unsigned SPC_LOG2 = 3,
  parameter int unsigned BW = SPC_LOG2 + 1
) (
  input  logic [23:0]   cluster_i,
  input  logic [BW-1:0] blk_idx_i,
  output logic [31:0]   data_sector_o,
  output logic [31:0]   fat_sector_o,
  output logic [8:0]    target_byte_o,
  output logic          straddle_o
);
  logic [31:0] fat_byte;
  assign fat_byte = 32'(cluster_i) * 32'd3;
  assign data_sector_o = 32'(DATA_START_SECTOR) + ((32'(cluster_i) - 32'd2) << SPC_LOG2) + 32'(blk_idx_i);
  assign fat_sector_o = 32'(FAT_START_SECTOR) + (fat_byte >> 9);
  assign target_byte_o = fat_byte[8:0];
  assign straddle_o = target_byte_o >= 9'd510;
endmodule

// File: rtl/fat_chain_sequencer.sv
// fat_chain_sequencer: walks a FAT24 cluster chain, issuing data and FAT block requests
module fat_chain_sequencer
  import fat_pkg::*;
#(
  parameter int unsigned FAT_START_SECTOR = 32,
  parameter int unsigned DATA_START_SECTOR = 2048,
  parameter int unsigned SPC_LOG2 = 3,
  parameter logic [23:0] EOC_MIN = EOC_MIN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [23:0] start_cluster_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        file_done_o,
  output logic        error_o,
  output logic [1:0]  selector_o,
  output logic [31:0] target_byte_o,
  output logic [32:0] cluster_offset_o,
  output logic        req_valid_o,
  output logic [31:0] sector_addr_o,
  input  logic        addr_done_i,
  input  logic        data_done_i,
  input  logic        valid_cluster_i,
  input  logic [23:0] cluster_data_i,
  input  logic        fifo_space_ok_i
);
  localparam int unsigned BW = SPC_LOG2 + 1;
  localparam logic [BW-1:0] BLK_LAST = BW'((1 << SPC_LOG2) - 1);
  state_t state_q, state_d;
  logic [23:0] cur_q, cur_d;
  logic [BW-1:0] blk_q, blk_d;
  logic abort_q, abort_d, addr_prev_q, err_q, err_d, done_q, done_d, req, bad, eoc, straddle;
  logic [1:0] sel_q, sel_d;
  logic [31:0] sector_q, sector_d, target_q, target_d, data_sector, fat_sector;
  logic [32:0] offset_q, offset_d;
  logic [8:0] target;
  fat_addr_calc #(
    .FAT_START_SECTOR(FAT_START_SECTOR),
    .DATA_START_SECTOR(DATA_START_SECTOR),
    .SPC_LOG2(SPC_LOG2),
    .BW(BW)
  ) u_calc (
    .cluster_i(cur_d),
    .blk_idx_i(blk_d),
    .data_sector_o(data_sector),
    .fat_sector_o(fat_sector),
    .target_byte_o(target),
    .straddle_o(straddle)
  );
  assign bad = cur_q < 24'd2 || cur_q >= EOC_MIN;
  assign eoc = cluster_data_i >= EOC_MIN;
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    blk_d = blk_q;
    abort_d = abort_q | abort_i;
    err_d = 1'b0;
    done_d = 1'b0;
    req = 1'b0;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (start_i) begin
          cur_d = start_cluster_i;
          blk_d = '0;
          state_d = DATA_REQ;
        end
      end
      DATA_REQ:
        if (abort_q) state_d = IDLE;
        else if (bad) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else if (addr_done_i && fifo_space_ok_i) begin
          req = 1'b1;
          state_d = DATA_WAIT;
        end
      DATA_WAIT:
        if (data_done_i) begin
          blk_d = blk_q + BW'(1);
          state_d = abort_d ? IDLE : blk_q == BLK_LAST ? FAT_REQ : DATA_REQ;
        end
      FAT_REQ, FAT_REQ2:
        if (abort_q) state_d = IDLE;
        else if (addr_done_i) begin
          req = 1'b1;
          state_d = state_q == FAT_REQ ? FAT_WAIT : FAT_WAIT2;
        end
      FAT_WAIT, FAT_WAIT2:
        // a straddling entry needs the second sector before any cluster is valid
        if (state_q == FAT_WAIT && offset_q == 33'd1) begin
          if (addr_done_i && !addr_prev_q) state_d = abort_d ? IDLE : FAT_REQ2;
        end else if (valid_cluster_i) begin
          if (abort_d) state_d = IDLE;
          else begin
            cur_d = cluster_data_i;
            blk_d = '0;
            done_d = eoc;
            state_d = eoc ? IDLE : DATA_REQ;
          end
        end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) abort_d = 1'b0;
  end
  // request fields are loaded on entry to a request state so they are settled before req_valid
  assign sel_d = state_d == DATA_REQ ? SEL_DATA : (state_d == FAT_REQ || state_d == FAT_REQ2) ? SEL_FAT : sel_q;
  assign sector_d = state_d == DATA_REQ ? data_sector : state_d == FAT_REQ ? fat_sector :
                    (state_d == FAT_REQ2 && state_q == FAT_WAIT) ? sector_q + 32'd1 : sector_q;
  assign target_d = state_d == FAT_REQ ? {23'd0, target} : target_q;
  assign offset_d = state_d == FAT_REQ ? (straddle ? 33'd1 : 33'd3) : state_d == FAT_REQ2 ? 33'd2 : offset_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q <= '0;
      blk_q <= '0;
      abort_q <= 1'b0;
      addr_prev_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      sel_q <= SEL_DIR;
      sector_q <= '0;
      target_q <= '0;
      offset_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      blk_q <= blk_d;
      abort_q <= abort_d;
      addr_prev_q <= addr_done_i;
      err_q <= err_d;
      done_q <= done_d;
      sel_q <= sel_d;
      sector_q <= sector_d;
      target_q <= target_d;
      offset_q <= offset_d;
    end
  end
  assign busy_o = state_q != IDLE;
  assign req_valid_o = req;
  assign file_done_o = done_q;
  assign error_o = err_q;
  assign selector_o = sel_q;
  assign sector_addr_o = sector_q;
  assign target_byte_o = target_q;
  assign cluster_offset_o = offset_q;
endmodule

// File: tb/tb_fat_chain_sequencer.sv
// tb_fat_chain_sequencer: directed vectors over chain walk, straddle, flow control, abort, error and reset
module tb_fat_chain_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, addr_done = 1'b0, data_done = 1'b0;
  logic valid_cluster = 1'b0, fifo_ok = 1'b0;
  logic [23:0] start_cluster = '0, cluster_data = '0;
  logic busy, file_done, error, req_valid;
  logic [1:0] selector;
  logic [31:0] target_byte, sector_addr;
  logic [32:0] cluster_offset;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  fat_chain_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start), .start_cluster_i(start_cluster), .abort_i(abort),
    .busy_o(busy), .file_done_o(file_done), .error_o(error), .selector_o(selector),
    .target_byte_o(target_byte), .cluster_offset_o(cluster_offset), .req_valid_o(req_valid),
    .sector_addr_o(sector_addr), .addr_done_i(addr_done), .data_done_i(data_done),
    .valid_cluster_i(valid_cluster), .cluster_data_i(cluster_data), .fifo_space_ok_i(fifo_ok)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_chk(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_req"}, 64'(req_valid), 64'd0);
    chk({tag, "_done"}, 64'(file_done), 64'd0);
    chk({tag, "_err"}, 64'(error), 64'd0);
    chk({tag, "_sel"}, 64'(selector), 64'd0);
    chk({tag, "_sector"}, 64'(sector_addr), 64'd0);
    chk({tag, "_target"}, 64'(target_byte), 64'd0);
    chk({tag, "_offset"}, 64'(cluster_offset), 64'd0);
  endtask
  task automatic start_file(input logic [23:0] c, input logic ab);
    step(); start = 1'b1; start_cluster = c; abort = ab; #1;
    step(); start = 1'b0; abort = 1'b0; #1;
  endtask
  task automatic run_blocks(input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      chk("data_req_valid", 64'(req_valid), 64'd1);
      chk("data_sel", 64'(selector), 64'd2);
      chk("data_sector", 64'(sector_addr), 64'(base + 32'(i)));
      step(); addr_done = 1'b0; #1;
      chk("data_wait_no_req", 64'(req_valid), 64'd0);
      step(); data_done = 1'b1; addr_done = 1'b1; #1;
      step(); data_done = 1'b0; #1;
    end
  endtask
  task automatic fat_chk(input logic [31:0] sec, input logic [31:0] tb, input logic [32:0] off);
    chk("fat_req_valid", 64'(req_valid), 64'd1);
    chk("fat_sel", 64'(selector), 64'd1);
    chk("fat_sector", 64'(sector_addr), 64'(sec));
    chk("fat_target", 64'(target_byte), 64'(tb));
    chk("fat_offset", 64'(cluster_offset), 64'(off));
  endtask
  task automatic fat_ret(input logic [23:0] d);
    step(); addr_done = 1'b0; #1;
    step(); valid_cluster = 1'b1; cluster_data = d; addr_done = 1'b1; #1;
    step(); valid_cluster = 1'b0; #1;
  endtask
  task automatic straddle_hop();
    step(); addr_done = 1'b0; #1;
    step(); addr_done = 1'b1; #1;
    step(); #1;
  endtask
  initial begin
    int n;
    step(); step();
    reset_chk("reset");
    rst = 1'b0; addr_done = 1'b1; fifo_ok = 1'b1;
    // cluster 5: sectors 2072..2079, FAT entry at byte 15 of sector 32, then end of chain
    start_file(24'd5, 1'b0);
    chk("a_busy", 64'(busy), 64'd1);
    run_blocks(32'd2072);
    fat_chk(32'd32, 32'd15, 33'd3);
    fat_ret(24'hFFFFFF);
    chk("a_done_pulse", 64'(file_done), 64'd1);
    chk("a_idle", 64'(busy), 64'd0);
    step(); #1;
    chk("a_done_clear", 64'(file_done), 64'd0);
    // cluster 170: FAT entry at byte 510 straddles sectors 32/33, next cluster 9
    start_file(24'd170, 1'b0);
    run_blocks(32'd3392);
    fat_chk(32'd32, 32'd510, 33'd1);
    straddle_hop();
    fat_chk(32'd33, 32'd510, 33'd2);
    fifo_ok = 1'b0;
    fat_ret(24'd9);
    chk("b_no_done", 64'(file_done), 64'd0);
    chk("b_next_sector", 64'(sector_addr), 64'd2104);
    chk("b_hold_req", 64'(req_valid), 64'd0);
    n = 0;
    repeat (100) begin
      step(); #1;
      if (req_valid) n++;
    end
    chk("c_fifo_hold", 64'(n), 64'd0);
    fifo_ok = 1'b1; #1;
    chk("c_fifo_release", 64'(req_valid), 64'd1);
    // abort during DATA_WAIT: in-flight block completes, then idle
    step(); addr_done = 1'b0; abort = 1'b1; #1;
    step(); abort = 1'b0; #1;
    chk("d_still_busy", 64'(busy), 64'd1);
    step(); data_done = 1'b1; addr_done = 1'b1; #1;
    step(); data_done = 1'b0; #1;
    chk("d_idle", 64'(busy), 64'd0);
    chk("d_no_done", 64'(file_done), 64'd0);
    n = 0;
    repeat (5) begin
      step(); #1;
      if (req_valid) n++;
    end
    chk("d_no_req", 64'(n), 64'd0);
    // illegal start clusters
    start_file(24'd1, 1'b0);
    chk("e1_no_req", 64'(req_valid), 64'd0);
    step(); #1;
    chk("e1_err", 64'(error), 64'd1);
    chk("e1_busy", 64'(busy), 64'd0);
    step(); #1;
    chk("e1_err_clear", 64'(error), 64'd0);
    start_file(24'hFFFFF8, 1'b0);
    chk("e2_no_req", 64'(req_valid), 64'd0);
    step(); #1;
    chk("e2_err", 64'(error), 64'd1);
    // abort alone in IDLE, then start with coincident abort: start wins
    step(); abort = 1'b1; #1;
    step(); abort = 1'b0; #1;
    chk("f_idle_abort", 64'(busy), 64'd0);
    start_file(24'd2, 1'b1);
    chk("f_busy", 64'(busy), 64'd1);
    run_blocks(32'd2048);
    fat_chk(32'd32, 32'd6, 33'd3);
    fat_ret(24'd170);
    chk("f_chain_busy", 64'(busy), 64'd1);
    run_blocks(32'd3392);
    fat_chk(32'd32, 32'd510, 33'd1);
    straddle_hop();
    fat_chk(32'd33, 32'd510, 33'd2);
    step(); addr_done = 1'b0; #1;
    chk("g_wait2_busy", 64'(busy), 64'd1);
    // reset during FAT_WAIT2, then late completions must be ignored
    rst = 1'b1;
    step();
    reset_chk("g_rst");
    rst = 1'b0; valid_cluster = 1'b1; data_done = 1'b1; addr_done = 1'b1; cluster_data = 24'd5;
    step(); valid_cluster = 1'b0; data_done = 1'b0; #1;
    chk("g_late_busy", 64'(busy), 64'd0);
    chk("g_late_req", 64'(req_valid), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fat_chain_sequencer.md
FAT_CHAIN_SEQUENCER -- requirements
Module: fat_chain_sequencer

Interface
REQ-001 SHALL have parameters: FAT_START_SECTOR, default 32, first FAT sector; DATA_START_SECTOR, default 2048, sector of cluster 2; SPC_LOG2, default 3, log2 of sectors per cluster; EOC_MIN, default 24'hFFFFF8, lowest end-of-chain value.
REQ-002 SHALL have one clock; reset is synchronous and active-high: clk input 1 system clock; rst input 1 synchronous active-high reset.
REQ-003 SHALL have host ports: start input 1 one-cycle file start pulse; start_cluster input 24 first cluster; abort input 1 stop request; busy output 1 sequence in progress; file_done output 1 one-cycle pulse at end of chain; error output 1 one-cycle pulse for an illegal cluster.
REQ-004 SHALL have addressor ports: selector output 2 (01 FAT, 10 data); target_byte output 32; cluster_offset output 33; req_valid output 1 one-cycle block request; sector_addr output 32 SD block address; addr_done input 1 addressor idle; data_done input 1; valid_cluster input 1; cluster_data input 24 FAT entry.
REQ-005 SHALL have flow-control port fifo_space_ok input 1, high when the downstream FIFO can accept 512 bytes.

Function
REQ-006 SHALL implement states IDLE, DATA_REQ, DATA_WAIT, FAT_REQ, FAT_WAIT, FAT_REQ2, FAT_WAIT2.
REQ-007 IDLE: on start, SHALL latch start_cluster into cur_cluster, clear blk_idx, and go to DATA_REQ; start outside IDLE SHALL be ignored.
REQ-008 On entering DATA_REQ, SHALL pulse error and return to IDLE if cur_cluster < 2 or cur_cluster >= EOC_MIN.
REQ-009 DATA_REQ: when addr_done and fifo_space_ok are both 1, SHALL pulse req_valid for one cycle with selector=10 and sector_addr=DATA_START_SECTOR+((cur_cluster-2)<<SPC_LOG2)+blk_idx, then go to DATA_WAIT.
REQ-010 All address arithmetic SHALL be 32-bit unsigned; overflow wraps and is not flagged.
REQ-011 DATA_WAIT: on data_done, SHALL increment blk_idx; if blk_idx was 2^SPC_LOG2-1, it SHALL go to FAT_REQ, otherwise to DATA_REQ.
REQ-012 FAT_REQ: fat_byte = cur_cluster*3 (32-bit); SHALL drive sector_addr=FAT_START_SECTOR+(fat_byte>>9) and target_byte=fat_byte[8:0].
REQ-013 When target_byte<=509, FAT_REQ SHALL drive cluster_offset=3; when target_byte is 510 or 511, it SHALL drive cluster_offset=1 (the entry straddles the sector boundary).
REQ-014 FAT_REQ SHALL pulse req_valid with selector=01 when addr_done=1, then go to FAT_WAIT.
REQ-015 FAT_WAIT, non-straddle: on valid_cluster, SHALL latch cluster_data into cur_cluster, clear blk_idx, and go to DATA_REQ.
REQ-016 FAT_WAIT, straddle: on the addr_done rising edge, SHALL go to FAT_REQ2.
REQ-017 FAT_REQ2 SHALL request sector_addr+1 with cluster_offset=2, same target_byte, when addr_done=1; FAT_WAIT2 SHALL latch on valid_cluster as in REQ-015.
REQ-018 If cluster_data >= EOC_MIN, SHALL pulse file_done and go to IDLE instead of DATA_REQ.
REQ-019 req_valid SHALL never assert while addr_done=0, and never in two consecutive cycles.
REQ-020 Outputs selector, sector_addr, target_byte and cluster_offset SHALL be registered and held stable from the req_valid cycle until the matching completion.
REQ-021 abort SHALL be latched; the block in flight completes, then the block returns to IDLE without pulsing file_done; abort in IDLE has no effect.
REQ-022 If start and abort coincide in IDLE, start SHALL win and the abort latch SHALL be cleared.
REQ-023 busy SHALL be 1 in every state except IDLE.

Reset
REQ-024 On rst, SHALL enter IDLE with req_valid, busy, file_done, error, the abort latch, blk_idx, cur_cluster, sector_addr, target_byte and cluster_offset all 0, and selector=00.
REQ-025 rst mid-operation SHALL take effect the next cycle; no further req_valid SHALL be issued, and late data_done or valid_cluster pulses SHALL be ignored in IDLE.

Structure
REQ-026 State enum, selector codes (SEL_DIR=00, SEL_FAT=01, SEL_DATA=10) and EOC_MIN default SHALL live in shared package fat_pkg.
REQ-027 Sub-module fat_addr_calc (combinational: cluster and blk_idx in, data sector, FAT sector, target_byte and straddle flag out) is natural; all remaining logic stays single-module.

Verification
REQ-028 With start_cluster=5 and SPC_LOG2=3: SHALL issue data sectors 2072..2079, then a FAT request for sector 32 with target_byte=15 and cluster_offset=3; returning cluster_data=FFFFFF SHALL give a file_done pulse.
REQ-029 With start_cluster=170 (fat_byte=510): SHALL issue a FAT read of sector 32 with offset 1, then sector 33 with offset 2; cluster_data=9 SHALL give the next data sector 2104.
REQ-030 Holding fifo_space_ok=0 for 100 cycles in DATA_REQ SHALL produce no req_valid; raising it SHALL produce req_valid within 1 cycle.
REQ-031 start_cluster=1 SHALL give an error pulse, busy=0, and no req_valid.
REQ-032 abort asserted during DATA_WAIT SHALL be followed by data_done, then IDLE with no further requests and no file_done; rst asserted during FAT_WAIT2 SHALL leave all outputs at reset values the next cycle.
